trace_capture_ctrl: RTL and testbench

Sequencer for one sensor trace acquisition in the system clock domain. After a start pulse it clears the sensor FIFO, waits a programmable arm delay, and fires the capture trigger. It then waits for the FIFO to report the capture complete and drains the N_SAMPLES 128-bit samples one at a time onto a valid/ack output toward the ciphertext FIFO path. It replaces ad-hoc CPU sequencing of the sensor FIFO and reports busy, done and timeout status.

---
 rtl/trace_capture_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_trace_capture_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_capture_ctrl.sv
// Sequencer for one sensor trace: clear the sensor FIFO, arm, trigger, wait for capture,
// then drain N_SAMPLES 128-bit samples one at a time over a valid/ack handshake.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for start_i
// CLEAR     | fifo_rst_o held high for CLR_CYCLES cycles
// ARM       | PRE_DELAY idle cycles before the trigger (skipped if 0)
// TRIG      | one-cycle cap_trg_o
// CAPTURE   | waiting for cap_done_i, no timeout
// READ      | one-cycle fifo_rd_o
// WAIT_DV   | waiting up to TIMEOUT cycles for fifo_dvld_i
// PRESENT   | dout_vld_o high until dout_ack_i
// DONE      | one-cycle done_o, then IDLE
module trace_capture_ctrl #(
  parameter int N_SAMPLES  = 2048,
  parameter int CNT_W      = 12,
  parameter int CLR_CYCLES = 4,
  parameter int PRE_DELAY  = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               abort_i,
  output logic               fifo_rst_o,
  output logic               cap_trg_o,
  input  logic               cap_done_i,
  output logic               fifo_rd_o,
  input  logic               fifo_dvld_i,
  input  logic [127:0]       fifo_din_i,
  output logic [127:0]       dout_o,
  output logic               dout_vld_o,
  input  logic               dout_ack_i,
  output logic [CNT_W-1:0]   sample_cnt_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLEAR,
    S_ARM,
    S_TRIG,
    S_CAPTURE,
    S_READ,
    S_WAIT_DV,
    S_PRESENT,
    S_DONE
  } state_t;

  // One shared down-counter serves the clear, arm and read-timeout phases.
  localparam int TMR_MAX_A = (CLR_CYCLES > PRE_DELAY) ? CLR_CYCLES : PRE_DELAY;
  localparam int TMR_MAX   = (TMR_MAX_A > TIMEOUT) ? TMR_MAX_A : TIMEOUT;
  localparam int TMR_W     = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0] CLR_LOAD = TMR_W'(CLR_CYCLES - 1);
  localparam logic [TMR_W-1:0] ARM_LOAD = TMR_W'((PRE_DELAY > 0) ? PRE_DELAY - 1 : 0);
  localparam logic [TMR_W-1:0] TMO_LOAD = TMR_W'(TIMEOUT - 1);
  localparam logic [CNT_W:0]   N_LAST   = (CNT_W+1)'(N_SAMPLES);

  state_t             state;
  state_t             state_nxt;
  logic [TMR_W-1:0]   tmr;
  logic               tmr_zero;
  logic [CNT_W:0]     cnt;
  logic [CNT_W:0]     cnt_inc;
  logic [127:0]       dout_q;
  logic               err_q;
  logic               start_acc;
  logic               timeout_hit;
  logic               sample_acc;
  logic               data_take;

  assign tmr_zero = (tmr == '0);
  assign cnt_inc  = cnt + (CNT_W+1)'(1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort outranks every other event.
  always_comb begin
    state_nxt   = state;
    start_acc   = 1'b0;
    timeout_hit = 1'b0;
    sample_acc  = 1'b0;
    data_take   = 1'b0;
    if (abort_i) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            start_acc = 1'b1;
            state_nxt = S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (tmr_zero) begin
            state_nxt = (PRE_DELAY == 0) ? S_TRIG : S_ARM;
          end
        end
        S_ARM: begin
          if (tmr_zero) begin
            state_nxt = S_TRIG;
          end
        end
        S_TRIG:    state_nxt = S_CAPTURE;
        S_CAPTURE: begin
          if (cap_done_i) begin
            state_nxt = S_READ;
          end
        end
        S_READ:    state_nxt = S_WAIT_DV;
        S_WAIT_DV: begin
          // Data arriving in the expiry cycle wins over the timeout.
          if (fifo_dvld_i) begin
            data_take = 1'b1;
            state_nxt = S_PRESENT;
          end else if (tmr_zero) begin
            timeout_hit = 1'b1;
            state_nxt   = S_DONE;
          end
        end
        S_PRESENT: begin
          if (dout_ack_i) begin
            sample_acc = 1'b1;
            state_nxt  = (cnt_inc == N_LAST) ? S_DONE : S_READ;
          end
        end
        S_DONE:    state_nxt = S_IDLE;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from the state register.
  always_comb begin
    fifo_rst_o = 1'b0;
    cap_trg_o  = 1'b0;
    fifo_rd_o  = 1'b0;
    dout_vld_o = 1'b0;
    done_o     = 1'b0;
    busy_o     = (state != S_IDLE);
    case (state)
      S_CLEAR:   fifo_rst_o = 1'b1;
      S_TRIG:    cap_trg_o  = 1'b1;
      S_READ:    fifo_rd_o  = 1'b1;
      S_PRESENT: dout_vld_o = 1'b1;
      S_DONE:    done_o     = 1'b1;
      default:   ;
    endcase
  end

  // Phase timer: loaded on entry to a timed state, counts down to terminal count 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr <= '0;
    end else if (state_nxt != state) begin
      case (state_nxt)
        S_CLEAR:   tmr <= CLR_LOAD;
        S_ARM:     tmr <= ARM_LOAD;
        S_WAIT_DV: tmr <= TMO_LOAD;
        default:   tmr <= '0;
      endcase
    end else if (!tmr_zero) begin
      tmr <= tmr - TMR_W'(1);
    end
  end

  // Sample counter and sticky error survive abort; only a new start or rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else if (start_acc) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      if (sample_acc) begin
        cnt <= cnt_inc;
      end
      if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
    end else if (data_take) begin
      dout_q <= fifo_din_i;
    end
  end

  assign dout_o       = dout_q;
  assign sample_cnt_o = cnt[CNT_W-1:0];
  assign err_o        = err_q;

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Scoreboard bench for trace_capture_ctrl: a FIFO model pushes expected samples,
// a monitor pops and compares whenever the DUT presents a sample or a done pulse.
module tb_trace_capture_ctrl;

  localparam int N   = 4;
  localparam int CW  = 3;
  localparam int CLR = 4;
  localparam int PRE = 3;
  localparam int TMO = 8;
  localparam logic [127:0] STRAY = {4{32'hDEAD_BEEF}};

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start_i = 1'b0;
  logic           abort_i = 1'b0;
  logic           cap_done_i = 1'b0;
  logic           fifo_dvld_i = 1'b0;
  logic [127:0]   fifo_din_i = '0;
  logic           dout_ack_i = 1'b0;
  logic           fifo_rst_o, cap_trg_o, fifo_rd_o, dout_vld_o, busy_o, done_o, err_o;
  logic [127:0]   dout_o;
  logic [CW-1:0]  sample_cnt_o;

  trace_capture_ctrl #(
    .N_SAMPLES(N), .CNT_W(CW), .CLR_CYCLES(CLR), .PRE_DELAY(PRE), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .fifo_rst_o(fifo_rst_o), .cap_trg_o(cap_trg_o), .cap_done_i(cap_done_i),
    .fifo_rd_o(fifo_rd_o), .fifo_dvld_i(fifo_dvld_i), .fifo_din_i(fifo_din_i),
    .dout_o(dout_o), .dout_vld_o(dout_vld_o), .dout_ack_i(dout_ack_i),
    .sample_cnt_o(sample_cnt_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [127:0] exp_q[$];
  logic [3:0]   exp_done_q[$];

  // knobs written by the stimulus while the affected path is quiet
  int          drop_from = 1000;
  int          late_idx = -1;
  int          late_lat = 1;
  logic [31:0] base32 = '0;
  bit          stray_dv = 1'b0;
  bit          force_ack = 1'b0;
  int          stall_sample = 0;
  int          stall_len = 0;

  int           rd_idx = 0, rd_total = 0, pend = 0, pend_idx = 0, last_rd_cyc = 0;
  logic [127:0] last_issued = '0;
  int           present_cnt = 0, unstable = 0, rd_while_vld = 0, done_cyc = 0;
  int           vld_len = 0, max_vld = 0;
  logic         prev_vld = 1'b0;
  logic [127:0] held = '0;
  int           stall_ctr = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  task automatic fail_now(input string msg);
    n_checks++;
    $display("FAIL %s", msg);
  endtask

  function automatic logic [127:0] mk_data(input logic [31:0] b, input int idx);
    logic [31:0] w;
    w = b + 32'(idx) + 32'd1;
    return {w ^ 32'hA500_0000, w ^ 32'h005A_0000, w ^ 32'h0000_3C00, w};
  endfunction

  // Sensor FIFO read side: data arrives one cycle (or late_lat) after each read pulse.
  always @(negedge clk) begin
    fifo_dvld_i = 1'b0;
    if (fifo_rst_o) begin
      rd_idx = 0; rd_total = 0; pend = 0;
    end
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        fifo_dvld_i = 1'b1;
        fifo_din_i  = mk_data(base32, pend_idx);
        exp_q.push_back(fifo_din_i);
        last_issued = fifo_din_i;
      end
    end
    if (fifo_rd_o) begin
      last_rd_cyc = cyc;
      rd_total++;
      if (rd_idx < drop_from) begin
        pend_idx = rd_idx;
        pend     = (rd_idx == late_idx) ? late_lat : 1;
      end
      rd_idx++;
    end
    if (stray_dv) begin
      fifo_dvld_i = 1'b1;
      fifo_din_i  = STRAY;
    end
  end

  // Consumer: immediate ack unless stalling the selected sample.
  always @(negedge clk) begin
    if (fifo_rst_o) stall_ctr = 0;
    if (dout_vld_o) begin
      if (present_cnt == stall_sample && stall_ctr < stall_len) begin
        dout_ack_i = 1'b0;
        stall_ctr++;
      end else begin
        dout_ack_i = 1'b1;
      end
    end else begin
      dout_ack_i = force_ack;
    end
  end

  // Monitor
  always @(posedge clk) begin
    #1;
    if (fifo_rst_o) begin
      present_cnt = 0; max_vld = 0;
    end
    if (dout_vld_o) begin
      if (!prev_vld) begin
        present_cnt++;
        vld_len = 1;
        held = dout_o;
        if (exp_q.size() == 0) fail_now($sformatf("sample: unexpected dout 0x%0h", dout_o));
        else check("sample", dout_o, exp_q.pop_front());
      end else begin
        vld_len++;
        if (dout_o !== held) unstable++;
      end
      if (vld_len > max_vld) max_vld = vld_len;
      if (fifo_rd_o) rd_while_vld++;
    end
    prev_vld = dout_vld_o;
    if (done_o) begin
      done_cyc = cyc;
      if (exp_done_q.size() == 0) fail_now($sformatf("done: unexpected pulse err=%0b cnt=%0d", err_o, sample_cnt_o));
      else check("done_status", {124'h0, err_o, sample_cnt_o}, {124'h0, exp_done_q.pop_front()});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  task automatic start_trace(output int t);
    start_i = 1'b1;
    t = cyc;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic pulse_cap_done();
    cap_done_i = 1'b1;
    @(negedge clk);
    cap_done_i = 1'b0;
  endtask

  task automatic wait_done(input string nm, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) fail_now($sformatf("%s: done_o not seen within 400 cycles", nm));
  endtask

  initial begin
    int t;
    bit ok;
    int trg_seen;

    repeat (3) @(negedge clk);
    check("reset_ctrl", {118'h0, fifo_rst_o, cap_trg_o, fifo_rd_o, dout_vld_o, busy_o, done_o, err_o, sample_cnt_o}, '0);
    check("reset_dout", dout_o, '0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Full trace
    base32 = 32'h0;
    start_trace(t);
    for (int k = 1; k <= 10; k++) begin
      check($sformatf("s1_seq_k%0d", k), {125'h0, busy_o, fifo_rst_o, cap_trg_o},
            {125'h0, 1'b1, (k <= CLR), (k == CLR + PRE + 1)});
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    exp_done_q.push_back({1'b0, 3'd4});
    pulse_cap_done();
    check("s1_rd_after_cap", 128'(fifo_rd_o), 128'(1));
    wait_done("s1", ok);
    if (ok) begin
      check("s1_busy_at_done", 128'(busy_o), 128'(1));
      @(negedge clk);
      check("s1_busy_after", 128'(busy_o), 128'(0));
      check("s1_reads", 128'(rd_total), 128'(4));
    end
    repeat (3) @(negedge clk);

    // Backpressure on sample 2
    base32 = 32'h100;
    stall_sample = 2;
    stall_len = 20;
    start_trace(t);
    repeat (10) @(negedge clk);
    exp_done_q.push_back({1'b0, 3'd4});
    pulse_cap_done();
    wait_done("s2", ok);
    check("s2_reads", 128'(rd_total), 128'(4));
    check("s2_dout_stable", 128'(unstable), 128'(0));
    check("s2_no_rd_in_stall", 128'(rd_while_vld), 128'(0));
    check("s2_stall_len", 128'(max_vld), 128'(21));
    stall_sample = 0;
    repeat (3) @(negedge clk);

    // Timeout on read 3
    base32 = 32'h200;
    drop_from = 2;
    start_trace(t);
    repeat (10) @(negedge clk);
    exp_done_q.push_back({1'b1, 3'd2});
    pulse_cap_done();
    wait_done("s3", ok);
    if (ok) begin
      check("s3_latency", 128'(cyc - last_rd_cyc), 128'(TMO + 1));
      check("s3_err", 128'(err_o), 128'(1));
      check("s3_reads", 128'(rd_total), 128'(3));
      repeat (3) @(negedge clk);
      check("s3_err_sticky", {126'h0, busy_o, err_o}, {126'h0, 2'b01});
    end
    drop_from = 1000;

    // Ignored inputs in CAPTURE, then data in the timeout cycle
    base32 = 32'h300;
    start_trace(t);
    check("s5_start_clears", {124'h0, err_o, sample_cnt_o}, '0);
    repeat (10) @(negedge clk);
    #2;
    start_i = 1'b1; stray_dv = 1'b1; force_ack = 1'b1;
    @(negedge clk);
    #2;
    start_i = 1'b0; stray_dv = 1'b0; force_ack = 1'b0;
    @(negedge clk);
    check("s5_ignored", {120'h0, busy_o, fifo_rst_o, cap_trg_o, dout_vld_o, fifo_rd_o, sample_cnt_o},
          {120'h0, 5'b10000, 3'd0});
    check("s5_dout_hold", dout_o, last_issued);
    late_idx = 0;
    late_lat = TMO;
    exp_done_q.push_back({1'b0, 3'd4});
    pulse_cap_done();
    wait_done("s5", ok);
    late_idx = -1;
    late_lat = 1;
    repeat (3) @(negedge clk);

    // Abort mid-drain, then a clean restart
    base32 = 32'h400;
    stall_sample = 2;
    stall_len = 1000;
    start_trace(t);
    repeat (10) @(negedge clk);
    pulse_cap_done();
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (dout_vld_o && present_cnt == 2) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) fail_now("s4: sample 2 never presented");
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("s4_abort", {121'h0, busy_o, dout_vld_o, done_o, err_o, sample_cnt_o}, {121'h0, 4'b0000, 3'd1});
    stall_sample = 0;
    stall_len = 0;
    repeat (5) @(negedge clk);
    base32 = 32'h500;
    start_trace(t);
    check("s4_restart_cnt", 128'(sample_cnt_o), 128'(0));
    repeat (10) @(negedge clk);
    exp_done_q.push_back({1'b0, 3'd4});
    pulse_cap_done();
    wait_done("s4_restart", ok);
    repeat (3) @(negedge clk);

    // Reset while in ARM
    start_trace(t);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("s6_reset_ctrl", {118'h0, fifo_rst_o, cap_trg_o, fifo_rd_o, dout_vld_o, busy_o, done_o, err_o, sample_cnt_o}, '0);
    check("s6_reset_dout", dout_o, '0);
    rst = 1'b0;
    trg_seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (cap_trg_o) trg_seen++;
      @(negedge clk);
    end
    check("s6_no_trig", 128'(trg_seen), 128'(0));

    check("exp_samples_drained", 128'(exp_q.size()), 128'(0));
    check("exp_done_drained", 128'(exp_done_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
